// File: rtl/imem_fetch_sequencer.sv
// Instruction-memory fetch sequencer: walks the PC one byte per cycle, packs 4 bytes into an
// instruction for decode, and lends the memory port to a program loader between fetches.
// Optional build macro IFETCH_COUNT_EN adds an accepted-instruction counter output.
module imem_fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned MEM_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        ld_valid,
  input  logic [63:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
`ifdef IFETCH_COUNT_EN
  output logic [31:0] inst_count,
`endif
  output logic        misalign_err
);

  localparam logic [63:0] ADDR_MASK = 64'(MEM_SIZE) - 64'd1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [31:0] inst_nxt;
  logic [63:0] inst_pc_nxt;
  logic        inst_valid_nxt;
  logic [63:0] mem_addr_nxt;
  logic [7:0]  mem_wdata_nxt;
  logic        mem_we_nxt;
  logic        ld_ready_nxt;
  logic        misalign_nxt;
  logic        capture_ld;

  // Next-state and registered-output computation
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    byte_cnt_nxt   = byte_cnt;
    inst_nxt       = inst;
    inst_pc_nxt    = inst_pc;
    inst_valid_nxt = inst_valid;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    capture_ld     = 1'b0;
    misalign_nxt   = misalign_err | (redirect_valid & (|redirect_pc[1:0]));

    case (state)
      S_IDLE: begin
        if (ld_valid) begin
          state_nxt  = S_LOAD;
          capture_ld = 1'b1;
        end else if (fetch_en) begin
          state_nxt    = S_FETCH;
          byte_cnt_nxt = 2'd0;
        end
      end
      S_FETCH: begin
        inst_nxt[{byte_cnt, 3'b000} +: 8] = mem_rdata;
        if (byte_cnt == 2'd3) begin
          state_nxt      = S_HOLD;
          byte_cnt_nxt   = 2'd0;
          inst_valid_nxt = 1'b1;
          inst_pc_nxt    = pc;
          pc_nxt         = (pc + 64'd4) & ADDR_MASK;
        end else begin
          byte_cnt_nxt = byte_cnt + 2'd1;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          inst_valid_nxt = 1'b0;
          if (ld_valid) begin
            state_nxt  = S_LOAD;
            capture_ld = 1'b1;
          end else if (fetch_en) begin
            state_nxt    = S_FETCH;
            byte_cnt_nxt = 2'd0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          capture_ld = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Redirect restarts fetch everywhere but LOAD, where it only retargets the PC
    if (redirect_valid) begin
      pc_nxt = {redirect_pc[63:2], 2'b00} & ADDR_MASK;
      if (state != S_LOAD) begin
        byte_cnt_nxt   = 2'd0;
        inst_valid_nxt = 1'b0;
        capture_ld     = 1'b0;
        state_nxt      = fetch_en ? S_FETCH : S_IDLE;
      end
    end

    // Memory port is set up one cycle ahead so it is stable for the whole access cycle
    if (capture_ld) begin
      mem_addr_nxt  = ld_addr & ADDR_MASK;
      mem_wdata_nxt = ld_data;
    end else if (state_nxt == S_FETCH) begin
      mem_addr_nxt = (pc_nxt + 64'(byte_cnt_nxt)) & ADDR_MASK;
    end

    mem_we_nxt   = (state_nxt == S_LOAD);
    ld_ready_nxt = (state_nxt == S_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= RESET_PC & ADDR_MASK;
      byte_cnt     <= 2'd0;
      inst         <= 32'd0;
      inst_pc      <= 64'd0;
      inst_valid   <= 1'b0;
      mem_addr     <= 64'd0;
      mem_we       <= 1'b0;
      mem_wdata    <= 8'd0;
      ld_ready     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      byte_cnt     <= byte_cnt_nxt;
      inst         <= inst_nxt;
      inst_pc      <= inst_pc_nxt;
      inst_valid   <= inst_valid_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_we       <= mem_we_nxt;
      mem_wdata    <= mem_wdata_nxt;
      ld_ready     <= ld_ready_nxt;
      misalign_err <= misalign_nxt;
    end
  end

`ifdef IFETCH_COUNT_EN
  // Counts decode handshakes; free-running wrap, untouched by redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_count <= 32'd0;
    end else if (inst_valid && inst_ready) begin
      inst_count <= inst_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed self-checking bench for imem_fetch_sequencer with a 256-byte memory model.
module tb_imem_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        misalign_err;
`ifdef IFETCH_COUNT_EN
  logic [31:0] inst_count;
`endif

  logic [7:0] mem [256];
  logic [7:0] ldb [4];
  int n_chk;
  int n_bad;

  imem_fetch_sequencer #(.RESET_PC(64'h0), .MEM_SIZE(256)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
`ifdef IFETCH_COUNT_EN
    .inst_count(inst_count),
`endif
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (!inst_valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, 64'(inst_valid), 64'd1);
  endtask

  initial begin
    int idx;
    clk = 1'b0;
    rst = 1'b1;
    fetch_en = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    ld_valid = 1'b0;
    ld_addr = 64'd0;
    ld_data = 8'd0;
    n_chk = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h8b; mem[1] = 8'h1f; mem[2] = 8'h03; mem[3] = 8'he5;
    mem[4] = 8'hf8; mem[5] = 8'h40; mem[6] = 8'h00; mem[7] = 8'ha4;
    mem[12] = 8'h37; mem[13] = 8'h01; mem[14] = 8'h00; mem[15] = 8'h80;
    mem[252] = 8'h13; mem[253] = 8'h05; mem[254] = 8'h10; mem[255] = 8'h00;
    ldb[0] = 8'h8b; ldb[1] = 8'h04; ldb[2] = 8'h00; ldb[3] = 8'h86;

    tick();
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);

    // First instruction: valid exactly on the fifth edge
    rst = 1'b0;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    repeat (4) tick();
    chk("lat_not_yet", 64'(inst_valid), 64'd0);
    tick();
    chk("i0_valid", 64'(inst_valid), 64'd1);
    chk("i0_inst", 64'(inst), 64'h e5031f8b);
    chk("i0_pc", inst_pc, 64'd0);

    // Second instruction held 3 cycles; loader waits through FETCH and HOLD
    tick();
    inst_ready = 1'b0;
    ld_valid = 1'b1;
    ld_addr = 64'd8;
    ld_data = ldb[0];
    for (int k = 0; k < 4; k++) begin
      chk("ld_blocked_fetch", 64'(ld_ready), 64'd0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk("i1_valid_held", 64'(inst_valid), 64'd1);
      chk("i1_inst_held", 64'(inst), 64'h a40040f8);
      chk("i1_pc_held", inst_pc, 64'd4);
      chk("ld_blocked_hold", 64'(ld_ready), 64'd0);
      if (k < 2) tick();
    end
    inst_ready = 1'b1;
    tick();
    chk("ld_first_ready", 64'(ld_ready), 64'd1);
    chk("ld_first_we", 64'(mem_we), 64'd1);
    chk("ld_first_addr", mem_addr, 64'd8);
    chk("ld_first_data", 64'(mem_wdata), 64'h8b);
    chk("ld_valid_drop", 64'(inst_valid), 64'd0);

    idx = 0;
    for (int k = 0; k < 10 && ld_valid; k++) begin
      if (ld_ready) begin
        idx++;
        if (idx < 4) begin
          ld_addr = 64'(8 + idx);
          ld_data = ldb[idx];
        end else begin
          ld_valid = 1'b0;
        end
      end
      tick();
    end
    chk("ld_bytes_done", 64'(idx), 64'd4);
    chk("ld_ready_idle", 64'(ld_ready), 64'd0);
    chk("ld_mem_word", 64'({mem[11], mem[10], mem[9], mem[8]}), 64'h8600048b);
    wait_valid(10, "i2_wait");
    chk("i2_inst", 64'(inst), 64'h8600048b);
    chk("i2_pc", inst_pc, 64'd8);

    // Misaligned redirect mid-FETCH
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h0E;
    tick();
    redirect_valid = 1'b0;
    chk("redir_misalign", 64'(misalign_err), 64'd1);
    chk("redir_valid", 64'(inst_valid), 64'd0);
    chk("redir_addr", mem_addr, 64'h0C);
    wait_valid(8, "i3_wait");
    chk("i3_pc", inst_pc, 64'h0C);
    chk("i3_inst", 64'(inst), 64'h80000137);

    // Redirect during HOLD with inst_ready drops the held instruction
    redirect_valid = 1'b1;
    redirect_pc = 64'hFC;
    tick();
    redirect_valid = 1'b0;
    chk("hold_redir_drop", 64'(inst_valid), 64'd0);
    chk("hold_redir_addr", mem_addr, 64'hFC);
    wait_valid(8, "i4_wait");
    chk("i4_pc", inst_pc, 64'hFC);
    chk("i4_inst", 64'(inst), 64'h00100513);
    chk("misalign_sticky", 64'(misalign_err), 64'd1);
    tick();
    chk("wrap_addr", mem_addr, 64'd0);
    wait_valid(8, "i5_wait");
    chk("wrap_pc", inst_pc, 64'd0);
    chk("wrap_inst", 64'(inst), 64'h e5031f8b);

    // Reset at byte_cnt=2
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(inst_valid), 64'd0);
    chk("mid_rst_addr", mem_addr, 64'd0);
    chk("mid_rst_inst", 64'(inst), 64'd0);
    chk("mid_rst_misalign", 64'(misalign_err), 64'd0);
`ifdef IFETCH_COUNT_EN
    chk("mid_rst_count", 64'(inst_count), 64'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    // fetch_en drops mid-FETCH: instruction still completes, then sequencer idles
    fetch_en = 1'b0;
    wait_valid(8, "i6_wait");
    chk("post_rst_pc", inst_pc, 64'd0);
    chk("post_rst_inst", 64'(inst), 64'h e5031f8b);
    repeat (4) tick();
    chk("idle_no_fetch", 64'(inst_valid), 64'd0);
    chk("idle_no_we", 64'(mem_we), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
